random_word_gen: RTL and testbench

// Parametrised successor to the parity-filtered random byte generator. Samples NUM_SRC entropy bits every clk.

---
 rtl/random_word_gen_if.sv | 15 +
 rtl/random_word_gen.sv | 166 ++++++++++++++++
 tb/tb_random_word_gen.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/random_word_gen_if.sv
// random_word_gen_if: valid/ready word channel out of the random word generator.
//   random_Word  WORD_W  assembled word, meaningful while o_Valid=1
//   o_Valid      1       word available
//   i_Ready      1       consumer takes the word when o_Valid && i_Ready at posedge clk
// The master modport is the producer side; the slave modport is the consumer side.
interface random_word_gen_if #(
  parameter int WORD_W = 8
);
  logic [WORD_W-1:0] random_Word;
  logic              o_Valid;
  logic              i_Ready;

  modport master (output random_Word, output o_Valid, input  i_Ready);
  modport slave  (input  random_Word, input  o_Valid, output i_Ready);
endinterface

// File: rtl/random_word_gen.sv
// random_word_gen: entropy-folding random word generator.
// Every clk, NUM_SRC entropy bits are synchronised and folded by XOR into one
// raw bit. Raw bits are optionally von Neumann debiased and shifted MSB-first
// into WORD_W-bit words, which leave on a valid/ready channel. A debounced
// push-button gates generation (continuous or one-shot), and a
// repetition-count health test latches a sticky fault on stuck entropy.
// Ports:
//   clk          in   1        system clock
//   reset        in   1        synchronous, active-high reset
//   entropy_In   in   NUM_SRC  asynchronous entropy bits
//   button_Trig  in   1        raw push-button level, active-high
//   bus          master        random_Word / o_Valid / i_Ready channel
//   random_On    out  1        debounced button state
//   o_Fault      out  1        sticky health-test failure
module random_word_gen #(
  parameter int          NUM_SRC       = 8,
  parameter int          WORD_W        = 8,
  parameter logic [24:0] DEBOUNCE_TIME = 25'd20000000,
  parameter bit          DEBIAS        = 1'b1,
  parameter bit          ONE_SHOT      = 1'b0,
  parameter int          REP_LIMIT     = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] entropy_In,
  input  logic               button_Trig,
  random_word_gen_if.master  bus,
  output logic               random_On,
  output logic               o_Fault
);

  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

  localparam int                BC_W    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [BC_W-1:0]   BC_LAST = BC_W'(WORD_W - 1);
  localparam int                ACC_W   = (WORD_W > 1) ? WORD_W - 1 : 1;
  localparam int                REP_W   = $clog2(REP_LIMIT + 1);
  localparam logic [REP_W-1:0]  REP_MAX = REP_W'(REP_LIMIT);
  localparam logic [24:0]       DB_MAX  = DEBOUNCE_TIME - 25'd1;

  logic [NUM_SRC-1:0] sync1, sync2;
  logic               raw_bit, prev_bit;
  logic [REP_W-1:0]   rep_cnt, rep_nxt;
  logic               fault_trip, fault_q;
  logic [24:0]        db_cnt;
  logic               on_d, enable;
  state_t             state;
  logic [BC_W-1:0]    bit_cnt;
  logic [ACC_W-1:0]   acc;
  logic               pair_phase, first_bit;
  logic               bit_ok, bit_val;
  logic [ACC_W:0]     cat;
  logic [WORD_W-1:0]  word_nxt, word_q;
  logic               valid_q;

  assign raw_bit   = ^sync2;
  assign random_On = (db_cnt == DB_MAX);
  assign enable    = ONE_SHOT ? (random_On & ~on_d) : random_On;
  assign o_Fault   = fault_q;

  assign bus.random_Word = word_q;
  assign bus.o_Valid     = valid_q;

  // Run length of identical raw bits, saturating at the trip point.
  assign rep_nxt    = (raw_bit != prev_bit) ? REP_W'(1) :
                      (rep_cnt == REP_MAX)  ? REP_MAX : rep_cnt + REP_W'(1);
  assign fault_trip = (rep_nxt == REP_MAX);

  // Bit acceptance: with debiasing, only the second bit of a pair can
  // accept, and it delivers the first bit of an unequal pair.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    bit_ok  = 1'b1;
    bit_val = raw_bit;
    if (DEBIAS) begin
      bit_ok  = pair_phase && (first_bit != raw_bit);
      bit_val = first_bit;
    end
  end

  // Earlier accepted bits sit above the new one, so the first bit ends as MSB.
  assign cat      = {acc, bit_val};
  assign word_nxt = cat[WORD_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1      <= '0;
      sync2      <= '0;
      prev_bit   <= 1'b0;
      rep_cnt    <= '0;
      fault_q    <= 1'b0;
      db_cnt     <= '0;
      on_d       <= 1'b0;
      state      <= IDLE;
      bit_cnt    <= '0;
      acc        <= '0;
      pair_phase <= 1'b0;
      first_bit  <= 1'b0;
      word_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout, so every decision below sees pre-edge state.
      sync1    <= entropy_In;
      sync2    <= sync1;
      prev_bit <= raw_bit;
      rep_cnt  <= rep_nxt;
      on_d     <= random_On;
      if (fault_trip) fault_q <= 1'b1;

      if (!button_Trig)       db_cnt <= '0;
      else if (db_cnt != DB_MAX) db_cnt <= db_cnt + 25'd1;

      // A fault (existing or tripping now) beats any word completing this edge.
      if (fault_q || fault_trip) begin
        state      <= IDLE;
        valid_q    <= 1'b0;
        bit_cnt    <= '0;
        pair_phase <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            bit_cnt    <= '0;
            pair_phase <= 1'b0;
            if (enable) state <= COLLECT;
          end
          COLLECT: begin
            if (!ONE_SHOT && !random_On) begin
              state <= IDLE;            // partial word is abandoned
            end else begin
              if (DEBIAS) begin
                pair_phase <= ~pair_phase;
                if (!pair_phase) first_bit <= raw_bit;
              end
              if (bit_ok) begin
                if (bit_cnt == BC_LAST) begin
                  word_q  <= word_nxt;
                  valid_q <= 1'b1;
                  bit_cnt <= '0;
                  state   <= HOLD;
                end else begin
                  acc     <= word_nxt[ACC_W-1:0];
                  bit_cnt <= bit_cnt + BC_W'(1);
                end
              end
            end
          end
          HOLD: begin
            // Raw bits arriving here are dropped; the word stays put until taken.
            if (valid_q && bus.i_Ready) begin
              valid_q <= 1'b0;
              if (!ONE_SHOT && random_On) begin
                state      <= COLLECT;
                bit_cnt    <= '0;
                pair_phase <= 1'b0;
              end else begin
                state <= IDLE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_random_word_gen.sv
// tb_random_word_gen: four generator configurations share clock, reset,
// button, ready and entropy. A behavioural model per configuration predicts
// every output each cycle; directed phases pin known words, the debounce
// sequence, one-shot behaviour, fault latching and reset recovery.
module tb_random_word_gen;

  typedef struct packed {
    int w, dt, rep, nsrc;
    bit debias, one_shot;
  } cfg_t;

  typedef struct {
    int     run;          // consecutive high button samples since reset
    bit     on_prev;
    int     n_edges;      // edges since reset, capped at 2
    bit     h0, h1;       // parity of entropy one and two edges back
    bit     prev_raw;
    int     rep;
    bit     fault;
    bit     collecting, holding;
    longint acc;
    int     nb;
    bit     hf, first;
    int     word;
    bit     valid;
  } mstate_t;

  localparam cfg_t CFG_A = '{w:8, dt:4, rep:32, nsrc:8, debias:1'b0, one_shot:1'b0};
  localparam cfg_t CFG_B = '{w:4, dt:4, rep:32, nsrc:3, debias:1'b1, one_shot:1'b0};
  localparam cfg_t CFG_C = '{w:8, dt:4, rep:32, nsrc:8, debias:1'b1, one_shot:1'b1};
  localparam cfg_t CFG_D = '{w:8, dt:4, rep:8,  nsrc:8, debias:1'b0, one_shot:1'b0};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       button = 1'b0;
  logic       ready = 1'b0;
  logic [7:0] ent = 8'h00;
  logic       on_a, on_b, on_c, on_d, fault_a, fault_b, fault_c, fault_d;
  int         n_checks = 0;
  int         n_fail = 0;
  mstate_t    ms_a, ms_b, ms_c, ms_d;

  always #5 clk = ~clk;

  random_word_gen_if #(.WORD_W(8)) bus_a ();
  random_word_gen_if #(.WORD_W(4)) bus_b ();
  random_word_gen_if #(.WORD_W(8)) bus_c ();
  random_word_gen_if #(.WORD_W(8)) bus_d ();
  assign bus_a.i_Ready = ready;
  assign bus_b.i_Ready = ready;
  assign bus_c.i_Ready = ready;
  assign bus_d.i_Ready = ready;

  random_word_gen #(.NUM_SRC(8), .WORD_W(8), .DEBOUNCE_TIME(25'd4), .DEBIAS(1'b0),
                    .ONE_SHOT(1'b0), .REP_LIMIT(32)) dut_a (
    .clk(clk), .reset(reset), .entropy_In(ent), .button_Trig(button),
    .bus(bus_a), .random_On(on_a), .o_Fault(fault_a));
  random_word_gen #(.NUM_SRC(3), .WORD_W(4), .DEBOUNCE_TIME(25'd4), .DEBIAS(1'b1),
                    .ONE_SHOT(1'b0), .REP_LIMIT(32)) dut_b (
    .clk(clk), .reset(reset), .entropy_In(ent[2:0]), .button_Trig(button),
    .bus(bus_b), .random_On(on_b), .o_Fault(fault_b));
  random_word_gen #(.NUM_SRC(8), .WORD_W(8), .DEBOUNCE_TIME(25'd4), .DEBIAS(1'b1),
                    .ONE_SHOT(1'b1), .REP_LIMIT(32)) dut_c (
    .clk(clk), .reset(reset), .entropy_In(ent), .button_Trig(button),
    .bus(bus_c), .random_On(on_c), .o_Fault(fault_c));
  random_word_gen #(.NUM_SRC(8), .WORD_W(8), .DEBOUNCE_TIME(25'd4), .DEBIAS(1'b0),
                    .ONE_SHOT(1'b0), .REP_LIMIT(8)) dut_d (
    .clk(clk), .reset(reset), .entropy_In(ent), .button_Trig(button),
    .bus(bus_d), .random_On(on_d), .o_Fault(fault_d));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_on(mstate_t s, cfg_t c);
    return s.run >= c.dt - 1;
  endfunction

  // One clock edge of the generator, described by its observable rules.
  function automatic mstate_t step(mstate_t s, cfg_t c, bit rst, bit btn,
                                   logic [7:0] e, bit rdy);
    mstate_t    n;
    logic [7:0] mask;
    bit         raw, on_now, en, fault_now, got, b;
    n = s;
    if (rst) begin
      n = '{default: 0};
      return n;
    end
    mask      = 8'((1 << c.nsrc) - 1);
    raw       = (s.n_edges >= 2) ? s.h1 : 1'b0;   // synchroniser delay, zeros after reset
    n.h1      = s.h0;
    n.h0      = ^(e & mask);
    n.n_edges = (s.n_edges < 2) ? s.n_edges + 1 : 2;
    on_now    = model_on(s, c);
    en        = c.one_shot ? (on_now && !s.on_prev) : on_now;
    n.rep     = (raw == s.prev_raw) ? ((s.rep < c.rep) ? s.rep + 1 : s.rep) : 1;
    n.prev_raw = raw;
    fault_now = s.fault || (n.rep >= c.rep);
    n.fault   = fault_now;
    n.on_prev = on_now;
    n.run     = btn ? ((s.run < 1000) ? s.run + 1 : s.run) : 0;
    if (fault_now) begin
      n.collecting = 0; n.holding = 0; n.valid = 0; n.nb = 0; n.hf = 0;
    end else if (s.holding) begin
      if (s.valid && rdy) begin
        n.valid = 0; n.holding = 0;
        if (!c.one_shot && on_now) begin
          n.collecting = 1; n.nb = 0; n.hf = 0;
        end
      end
    end else if (s.collecting) begin
      if (!c.one_shot && !on_now) begin
        n.collecting = 0; n.nb = 0; n.hf = 0;
      end else begin
        got = 1'b1;
        b   = raw;
        if (c.debias) begin
          if (!s.hf) begin
            n.hf = 1; n.first = raw; got = 1'b0;
          end else begin
            n.hf = 0; got = (s.first != raw); b = s.first;
          end
        end
        if (got) begin
          n.acc = (s.acc << 1) | longint'(b);
          n.nb  = s.nb + 1;
          if (n.nb == c.w) begin
            n.word = int'(n.acc & ((64'd1 << c.w) - 1));
            n.valid = 1; n.holding = 1; n.collecting = 0; n.nb = 0; n.acc = 0;
          end
        end
      end
    end else begin
      n.nb = 0; n.hf = 0;
      if (en) n.collecting = 1;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    ms_a <= step(ms_a, CFG_A, reset, button, ent, ready);
    ms_b <= step(ms_b, CFG_B, reset, button, ent, ready);
    ms_c <= step(ms_c, CFG_C, reset, button, ent, ready);
    ms_d <= step(ms_d, CFG_D, reset, button, ent, ready);
  end

  task automatic cmp(input string tag, input logic [31:0] w, input logic v,
                     input logic on, input logic f, input mstate_t s, input cfg_t c);
    check({tag, ".word"},  w,  32'(s.word));
    check({tag, ".valid"}, 32'(v),  32'(s.valid));
    check({tag, ".on"},    32'(on), 32'(model_on(s, c)));
    check({tag, ".fault"}, 32'(f),  32'(s.fault));
  endtask

  // Single compare process: every cycle, every configuration.
  always @(negedge clk) begin
    cmp("A", 32'(bus_a.random_Word), bus_a.o_Valid, on_a, fault_a, ms_a, CFG_A);
    cmp("B", 32'(bus_b.random_Word), bus_b.o_Valid, on_b, fault_b, ms_b, CFG_B);
    cmp("C", 32'(bus_c.random_Word), bus_c.o_Valid, on_c, fault_c, ms_c, CFG_C);
    cmp("D", 32'(bus_d.random_Word), bus_d.o_Valid, on_d, fault_d, ms_d, CFG_D);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic check_a_zero(input string tag);
    check({tag, ".word"},  32'(bus_a.random_Word), 32'h0);
    check({tag, ".valid"}, 32'(bus_a.o_Valid), 32'h0);
    check({tag, ".on"},    32'(on_a), 32'h0);
    check({tag, ".fault"}, 32'(fault_a), 32'h0);
  endtask

  initial begin
    logic [6:0]  btn_seq;
    logic [6:0]  on_exp;
    logic [7:0]  pat_a;
    logic [11:0] pat_b;
    bit          pa, pb;
    int          cnt, lat;

    // Reset state and debounce glitch rejection (DEBOUNCE_TIME=4).
    ent = 8'($urandom);
    do_reset();
    check_a_zero("t1.reset");
    btn_seq = 7'b1101111;
    on_exp  = 7'b0000011;
    for (int i = 6; i >= 0; i--) begin
      button = btn_seq[i];
      ent    = 8'($urandom);
      tick();
      check($sformatf("t1.on[%0d]", 6 - i), 32'(on_a), 32'(on_exp[i]));
    end
    button = 1'b0;
    tick();
    check("t1.on_release", 32'(on_a), 32'h0);

    // Known raw streams: A sees 1,0,1,1,0,0,1,0; B sees pairs 10,00,01,11,10,10.
    do_reset();
    button = 1'b1;
    ready  = 1'b0;
    pat_a  = 8'b1011_0010;
    pat_b  = 12'b1000_0111_1010;
    for (int j = 1; j <= 16; j++) begin
      pa  = (j >= 3 && j <= 10) ? pat_a[7 - (j - 3)]  : 1'($urandom);
      pb  = (j >= 3 && j <= 14) ? pat_b[11 - (j - 3)] : 1'($urandom);
      ent = {pa ^ pb, 6'b0, pb};
      tick();
      if (j >= 12) begin
        check($sformatf("t2.valid_hold%0d", j), 32'(bus_a.o_Valid), 32'h1);
        check($sformatf("t2.word_hold%0d", j), 32'(bus_a.random_Word), 32'hB2);
      end
    end
    check("t2.model_word", 32'(ms_a.word), 32'hB2);
    check("t3.valid", 32'(bus_b.o_Valid), 32'h1);
    check("t3.word", 32'(bus_b.random_Word), 32'hB);
    check("t3.model_word", 32'(ms_b.word), 32'hB);
    ent = 8'($urandom);
    tick();
    check("t2.word_stable5", 32'(bus_a.random_Word), 32'hB2);
    ready = 1'b1;
    tick();
    check("t2.valid_after_ready", 32'(bus_a.o_Valid), 32'h0);
    check("t2.word_kept", 32'(bus_a.random_Word), 32'hB2);
    check("t3.valid_after_ready", 32'(bus_b.o_Valid), 32'h0);

    // One-shot: a long press yields one word, a second press one more.
    do_reset();
    button = 1'b1;
    ready  = 1'b1;
    for (int r = 0; r < 2; r++) begin
      cnt = 0;
      for (int j = 0; j < 200; j++) begin
        ent = 8'($urandom);
        tick();
        if (bus_c.o_Valid) cnt++;
      end
      check($sformatf("t4.oneshot_words%0d", r), 32'(cnt), 32'h1);
      button = 1'b0;
      for (int j = 0; j < 10; j++) begin
        ent = 8'($urandom);
        tick();
      end
      button = 1'b1;
    end

    // Stuck entropy trips the D health test on the 8th identical raw bit.
    do_reset();
    ent = 8'h00;
    cnt = 0;
    for (int j = 1; j <= 20; j++) begin
      tick();
      if (bus_d.o_Valid) cnt++;
      if (j == 7) check("t5.fault_before", 32'(fault_d), 32'h0);
      if (j == 8) check("t5.fault_trip", 32'(fault_d), 32'h1);
    end
    for (int j = 0; j < 30; j++) begin
      ent = 8'($urandom);
      tick();
      if (bus_d.o_Valid) cnt++;
    end
    check("t5.never_valid", 32'(cnt), 32'h0);
    check("t5.fault_sticky", 32'(fault_d), 32'h1);
    do_reset();
    check("t5.fault_cleared", 32'(fault_d), 32'h0);

    // Reset mid-collection and in HOLD, then resume with the expected latency.
    button = 1'b1;
    ready  = 1'b0;
    for (int j = 0; j < 8; j++) begin
      ent = 8'($urandom);
      tick();
    end
    do_reset();
    check_a_zero("t6.collect_reset");
    lat = -1;
    for (int k = 1; k <= 100 && lat < 0; k++) begin
      ent = 8'($urandom);
      tick();
      if (bus_a.o_Valid) lat = k;
    end
    check("t6.resume_latency", 32'(lat), 32'd12);
    ent = 8'($urandom);
    tick();
    do_reset();
    check_a_zero("t6.hold_reset");

    // Randomised run: slow button changes, random ready/entropy, rare resets.
    for (int j = 0; j < 4000; j++) begin
      if ($urandom_range(29, 0) == 0) button = ~button;
      ready = 1'($urandom);
      ent   = 8'($urandom);
      reset = ($urandom_range(399, 0) == 0);
      tick();
    end
    reset = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
